// File: rtl/bram_copy_master.sv
// bram_copy_master
//   Simple DMA engine that copies a block of words from one address range to
//   another over the shared single-port memory bus.
//   Each word is handled as READ (address out), WAIT (read_latency cycles),
//   then WRITE (strobe out). That gives read_latency+2 cycles per word.
//   The copy always runs in ascending address order.
//
// Parameters
//   data_width    bus data word width
//   address_width bus address width; pointers wrap modulo 2^address_width
//   len_width     width of the word-count input
//   read_latency  cycles from read address to valid bus_rdata (1..4)
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  one-cycle launch pulse, accepted only when idle
//   src_addr, dst_addr     first source / destination word address
//   length                 number of words to copy (0 finishes immediately)
//   abort                  stops an active copy without a done pulse
//   busy                   high while words are being moved
//   done                   one-cycle pulse on normal completion
//   bus_addr, bus_wr       bus address and write strobe
//   bus_wdata, bus_rdata   bus write / read data
//   checksum               running sum of copied words (only with the macro)
//
// Optional feature: define BRAM_COPY_CHECKSUM_EN to add the checksum output.

module bram_copy_master #(
  parameter int data_width    = 8,
  parameter int address_width = 16,
  parameter int len_width     = 16,
  parameter int read_latency  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [address_width-1:0] src_addr,
  input  logic [address_width-1:0] dst_addr,
  input  logic [len_width-1:0]     length,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [address_width-1:0] bus_addr,
  output logic                     bus_wr,
  output logic [data_width-1:0]    bus_wdata,
  input  logic [data_width-1:0]    bus_rdata
`ifdef BRAM_COPY_CHECKSUM_EN
  ,
  output logic [data_width-1:0]    checksum
`endif
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FINISH} state_t;

  localparam logic [1:0]               LAT_INIT = 2'(read_latency - 1);
  localparam logic [address_width-1:0] ADDR_ONE = {{(address_width-1){1'b0}}, 1'b1};
  localparam logic [len_width-1:0]     LEN_ONE  = {{(len_width-1){1'b0}}, 1'b1};

  state_t                   state, state_nxt;
  logic [address_width-1:0] src_ptr, dst_ptr;
  logic [len_width-1:0]     remaining;
  logic [1:0]               lat_cnt;
  logic [data_width-1:0]    capture;
  logic                     accept;

  // Pointer increment wraps naturally at the address width.
  function automatic logic [address_width-1:0] addr_inc(input logic [address_width-1:0] a);
    return a + ADDR_ONE;
  endfunction

  // Abort takes priority over a start that arrives in the same idle cycle.
  assign accept = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = (length == '0) ? FINISH : READ;
      READ:   state_nxt = WAIT;
      WAIT:   if (lat_cnt == 2'd0) state_nxt = WRITE;
      WRITE:  state_nxt = (remaining == LEN_ONE) ? FINISH : READ;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  // Bus outputs decode straight from state so an asynchronous reset clears
  // the write strobe immediately.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    unique case (state)
      READ, WAIT: begin
        busy     = 1'b1;
        bus_addr = src_ptr;
      end
      WRITE: begin
        busy      = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = dst_ptr;
        bus_wdata = capture;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
      capture   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= length;
          end
        end
        READ: lat_cnt <= LAT_INIT;
        WAIT: begin
          // Counter reaching zero marks the cycle where bus_rdata is valid.
          if (lat_cnt == 2'd0) capture <= bus_rdata;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end
        WRITE: begin
          src_ptr   <= addr_inc(src_ptr);
          dst_ptr   <= addr_inc(dst_ptr);
          remaining <= remaining - LEN_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef BRAM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + capture;
    end
  end
`endif

endmodule

// File: tb/tb_bram_copy_master.sv
// Testbench for bram_copy_master: two instances (16-bit address / latency 1,
// and 8-bit address / latency 3), each on its own behavioural memory slave.
module tb_bram_copy_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;

  logic        busy_a, done_a, wr_a;
  logic [15:0] addr_a;
  logic [7:0]  wdata_a, rdata_a;
  logic        busy_b, done_b, wr_b;
  logic [7:0]  addr_b, wdata_b, rdata_b;
`ifdef BRAM_COPY_CHECKSUM_EN
  logic [7:0]  cks_a, cks_b, cks_done;
`endif

  bram_copy_master #(.data_width(8), .address_width(16), .len_width(16), .read_latency(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .src_addr(src), .dst_addr(dst),
    .length(len), .abort(abort), .busy(busy_a), .done(done_a), .bus_addr(addr_a),
    .bus_wr(wr_a), .bus_wdata(wdata_a), .bus_rdata(rdata_a)
`ifdef BRAM_COPY_CHECKSUM_EN
    , .checksum(cks_a)
`endif
  );

  bram_copy_master #(.data_width(8), .address_width(8), .len_width(16), .read_latency(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .src_addr(src[7:0]), .dst_addr(dst[7:0]),
    .length(len), .abort(abort), .busy(busy_b), .done(done_b), .bus_addr(addr_b),
    .bus_wr(wr_b), .bus_wdata(wdata_b), .bus_rdata(rdata_b)
`ifdef BRAM_COPY_CHECKSUM_EN
    , .checksum(cks_b)
`endif
  );

  // Memory slaves with preload port; A has 1-cycle, B 3-cycle read latency.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] exp_a [256];
  logic [7:0] exp_b [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0, pl_da = '0, pl_db = '0;
  logic [7:0] rpa, rpb0, rpb1, rpb2;

  always @(posedge clk) begin
    if (pl_en) begin
      mem_a[pl_addr] <= pl_da;
      mem_b[pl_addr] <= pl_db;
    end else begin
      if (wr_a) mem_a[addr_a[7:0]] <= wdata_a;
      if (wr_b) mem_b[addr_b] <= wdata_b;
    end
    rpa  <= mem_a[addr_a[7:0]];
    rpb0 <= mem_b[addr_b];
    rpb1 <= rpb0;
    rpb2 <= rpb1;
  end
  assign rdata_a = rpa;
  assign rdata_b = rpb2;

  logic        sel = 1'b0;
  logic        busy_m, done_m, wr_m;
  logic [15:0] addr_m;
  always_comb begin
    busy_m = sel ? busy_b : busy_a;
    done_m = sel ? done_b : done_a;
    wr_m   = sel ? wr_b : wr_a;
    addr_m = sel ? {8'h00, addr_b} : addr_a;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic        busy_log [64];
  logic        wr_log   [64];
  logic [15:0] addr_log [64];

  // Starts a copy on the selected instance and follows it cycle by cycle,
  // sampling at the falling edge. Cycle 0 is the one carrying start.
  task automatic run_copy(input logic s, input logic [15:0] sa, input logic [15:0] da,
                          input logic [15:0] ln, input int abort_at, input int restart_at,
                          input int budget, output int cyc, output int nwr,
                          output logic busy_seen, output logic got_done);
    for (int i = 0; i < 64; i++) begin
      busy_log[i] = 1'b0; wr_log[i] = 1'b0; addr_log[i] = '0;
    end
    sel = s; src = sa; dst = da; len = ln;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    cyc = 0; nwr = 0; busy_seen = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < budget) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
      cyc++;
      if (cyc < 64) begin
        busy_log[cyc] = busy_m; wr_log[cyc] = wr_m; addr_log[cyc] = addr_m;
      end
      if (wr_m) nwr++;
      if (busy_m) busy_seen = 1'b1;
      if (done_m) begin
        got_done = 1'b1;
`ifdef BRAM_COPY_CHECKSUM_EN
        cks_done = s ? cks_b : cks_a;
`endif
      end
      if (cyc == restart_at) begin
        src = 16'h0033; dst = 16'h0090; len = 16'd2;
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end
      if (cyc == abort_at) abort = 1'b1;
    end
  endtask

  task automatic model_copy(input logic s, input logic [15:0] sa, input logic [15:0] da, input int n);
    for (int i = 0; i < n; i++) begin
      if (s) exp_b[8'(da + i)] = exp_b[8'(sa + i)];
      else   exp_a[8'(da + i)] = exp_a[8'(sa + i)];
    end
  endtask

  task automatic check_range(input string name, input logic s, input logic [15:0] da, input int n);
    logic [7:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = 8'(da + i);
      check(name, s ? mem_b[idx] : mem_a[idx], s ? exp_b[idx] : exp_a[idx]);
    end
  endtask

  typedef struct {
    logic        s;
    logic [15:0] sa;
    logic [15:0] da;
    logic [15:0] ln;
    int          exp_cyc;
    int          exp_wr;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc, nwr, act;
    logic        bs, gd;
    int          lat;

    for (int i = 0; i < 256; i++) begin
      exp_a[i] = 8'(i * 37 + 11);
      exp_b[i] = 8'(i * 53 + 7) ^ 8'h5A;
    end
    exp_a[8'h10] = 8'hA1; exp_a[8'h11] = 8'hB2; exp_a[8'h12] = 8'hC3; exp_a[8'h13] = 8'hD4;
    exp_a[8'hE0] = 8'h80; exp_a[8'hE1] = 8'h90; exp_a[8'hE2] = 8'h10;

    // word count 0, basic 4-word copy, single word, overlap with dst < src,
    // address wrap on the 8-bit instance, short copy at latency 3
    vt[0] = '{1'b0, 16'h0010, 16'h0020, 16'd0, 1, 0};
    vt[1] = '{1'b0, 16'h0010, 16'h0040, 16'd4, 13, 4};
    vt[2] = '{1'b0, 16'h0050, 16'h0060, 16'd1, 4, 1};
    vt[3] = '{1'b0, 16'h0090, 16'h008E, 16'd4, 13, 4};
    vt[4] = '{1'b1, 16'h00FE, 16'h007E, 16'd4, 21, 4};
    vt[5] = '{1'b1, 16'h0020, 16'h0030, 16'd2, 11, 2};

    // Preload both memories while reset is held
    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_addr = 8'(i); pl_da = exp_a[i]; pl_db = exp_b[i];
      @(negedge clk);
    end
    pl_en = 1'b0;

    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_wr", {wr_a, wr_b}, 0);
    check("reset_addr", addr_a, 0);
    check("reset_wdata", wdata_a, 0);
`ifdef BRAM_COPY_CHECKSUM_EN
    check("reset_checksum", cks_a, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_copy(vt[v].s, vt[v].sa, vt[v].da, vt[v].ln, -1, -1, 60, cyc, nwr, bs, gd);
      check("done_seen", gd, 1);
      check("done_latency", cyc, vt[v].exp_cyc);
      check("write_count", nwr, vt[v].exp_wr);
      check("busy_seen", bs, vt[v].ln != 0);
      lat = vt[v].s ? 3 : 1;
      if (vt[v].ln != 0) check("first_write_cycle", wr_log[lat + 2], 1);
      if (vt[v].s && vt[v].sa == 16'h00FE) begin
        check("wrap_read_addr_c11", addr_log[11], 16'h0000);
        check("wrap_read_addr_c16", addr_log[16], 16'h0001);
      end
      model_copy(vt[v].s, vt[v].sa, vt[v].da, int'(vt[v].ln));
      check_range("copy_data", vt[v].s, vt[v].da, int'(vt[v].ln));
      @(negedge clk);
      check("done_one_cycle", {done_m, busy_m}, 0);
    end

    // Abort during the third READ of an 8-word copy
    run_copy(1'b0, 16'h00A0, 16'h00C0, 16'd8, 7, -1, 30, cyc, nwr, bs, gd);
    check("abort_no_done", gd, 0);
    check("abort_writes", nwr, 2);
    check("abort_busy_before", busy_log[7], 1);
    check("abort_busy_after", busy_log[8], 0);
    model_copy(1'b0, 16'h00A0, 16'h00C0, 2);
    check_range("abort_data", 1'b0, 16'h00C0, 3);

    // A fresh copy after the abort behaves normally
    run_copy(1'b0, 16'h00B0, 16'h00D0, 16'd2, -1, -1, 40, cyc, nwr, bs, gd);
    check("post_abort_latency", cyc, 7);
    check("post_abort_writes", nwr, 2);
    model_copy(1'b0, 16'h00B0, 16'h00D0, 2);
    check_range("post_abort_data", 1'b0, 16'h00D0, 2);
    @(negedge clk);

    // Second start while busy (latency 3) is ignored; words are 5 cycles apart
    run_copy(1'b1, 16'h0040, 16'h0050, 16'd3, -1, 4, 40, cyc, nwr, bs, gd);
    check("ignore_start_latency", cyc, 16);
    check("ignore_start_writes", nwr, 3);
    check("write_spacing", {wr_log[5], wr_log[10], wr_log[15], wr_log[6]}, 4'b1110);
    model_copy(1'b1, 16'h0040, 16'h0050, 3);
    check_range("ignore_start_data", 1'b1, 16'h0050, 3);
    check_range("ignored_dst_untouched", 1'b1, 16'h0090, 2);
    @(negedge clk);
    check("ignore_start_idle", busy_b, 0);

    // start and abort together while idle: start is dropped
    sel = 1'b0; src = 16'h0010; dst = 16'h00F0; len = 16'd2;
    start_a = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort = 1'b0;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_a || done_a || wr_a) act++;
      @(negedge clk);
    end
    check("start_abort_idle", act, 0);

    // Reset asserted during a WRITE clears the strobe at once
    src = 16'h0060; dst = 16'h0070; len = 16'd4;
    start_a = 1'b1;
    act = 0;
    for (int i = 0; i < 20 && !wr_a; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      act++;
    end
    check("reset_mid_write_reached", wr_a, 1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_wr", wr_a, 0);
    check("reset_mid_busy", busy_a, 0);
    check("reset_mid_addr", addr_a, 0);
    @(negedge clk);
    check("reset_mid_no_write", mem_a[8'h70], exp_a[8'h70]);
    reset_n = 1'b1;
    @(negedge clk);

    // Copy 0x80, 0x90, 0x10 (sum wraps to 0x20)
    run_copy(1'b0, 16'h00E0, 16'h00E8, 16'd3, -1, -1, 40, cyc, nwr, bs, gd);
    check("sum_copy_latency", cyc, 10);
    model_copy(1'b0, 16'h00E0, 16'h00E8, 3);
    check_range("sum_copy_data", 1'b0, 16'h00E8, 3);
`ifdef BRAM_COPY_CHECKSUM_EN
    check("checksum_at_done", cks_done, 8'h20);
    @(negedge clk);
    @(negedge clk);
    check("checksum_stable", cks_a, 8'h20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
